// File: rtl/fcp_slave_ctrl.sv
// FCP slave logical layer: SBRRD/SBRWR decode, register file, PING/RESPOND sequencing
// and a stepped output-voltage ramp over a table of discrete levels.
module fcp_slave_ctrl #(
    parameter int unsigned              NUM_VOUT    = 3,
    parameter logic [8*NUM_VOUT-1:0]    VOUT_TABLE  = {8'd120, 8'd90, 8'd50},
    parameter int unsigned              STEP_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  max_vidx,
    input  logic        ping_from_master,
    input  logic        reset_from_master,
    input  logic        crc_error,
    input  logic        par_error,
    input  logic [23:0] rx_data,
    input  logic        rx_data_valid,
    input  logic        tx_done,
    output logic        pl_tx_en,
    output logic        pl_tx_type,
    output logic [15:0] pl_tx_data,
    output logic [2:0]  out_vidx,
    output logic        vout_busy
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND_PING = 2'd1;
    localparam logic [1:0] SEND_RESP = 2'd2;
    localparam logic [7:0] ACK       = 8'h08;
    localparam logic [7:0] NACK      = 8'h03;
    localparam int unsigned CW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [2:0] TOP_IDX   = 3'(NUM_VOUT - 1);

    logic [2:0]    max_eff;
    logic [1:0]    state_q, state_d;
    logic          pending_q, pending_d;
    logic          send_ping, send_resp;
    logic          dec_vld_q, dec_wr_q, dec_rd_q;
    logic [7:0]    dec_addr_q, dec_wdata_q;
    logic          resp_vld_q;
    logic [7:0]    resp_q, resp_d;
    logic          rd_hit, wr_hit;
    logic [7:0]    rdata, vout_status;
    logic [7:0]    vout_cfg_q, vout_cfg_d;
    logic [1:0]    sstat_q, sstat_d;
    logic          adapt_q, adapt_d;
    logic          match;
    logic [2:0]    match_idx;
    logic          do_oc;
    logic [2:0]    target_q, target_d;
    logic [2:0]    out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_d;

    assign max_eff = (max_vidx > TOP_IDX) ? TOP_IDX : max_vidx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (ping_from_master) state_d = SEND_PING;
            SEND_PING: begin
                if (reset_from_master)  state_d = IDLE;
                else if (tx_done)       state_d = pending_q ? SEND_RESP : IDLE;
            end
            SEND_RESP: if (tx_done || reset_from_master) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign send_ping  = (state_q == IDLE) && (state_d == SEND_PING);
    assign send_resp  = (state_q == SEND_PING) && (state_d == SEND_RESP);
    assign pl_tx_en   = send_ping | send_resp;
    assign pl_tx_type = (state_d == SEND_RESP);

    always_comb begin
        pending_d = pending_q;
        if (reset_from_master)  pending_d = 1'b0;
        else if (rx_data_valid) pending_d = 1'b1;
        else if (send_resp)     pending_d = 1'b0;
    end

    // Register map read decode; table levels live at 0x30..0x30+max_eff.
    always_comb begin
        rd_hit = 1'b1;
        rdata  = 8'h00;
        case (dec_addr_q)
            8'h00: rdata = 8'h01;
            8'h01: rdata = 8'h20;
            8'h02: rdata = 8'h00;
            8'h03: rdata = {6'b0, sstat_q};
            8'h04: rdata = 8'hBB;
            8'h20: rdata = 8'h01;
            8'h21: rdata = {5'b0, max_eff};
            8'h22: rdata = 8'h24;
            8'h28: rdata = {6'b0, vout_busy, adapt_q};
            8'h29: rdata = vout_status;
            8'h2B: rdata = 8'h00;
            8'h2C: rdata = vout_cfg_q;
            default: begin
                rd_hit = 1'b0;
                for (int i = 0; i < NUM_VOUT; i++) begin
                    if (dec_addr_q == 8'(8'h30 + i) && 3'(i) <= max_eff) begin
                        rd_hit = 1'b1;
                        rdata  = VOUT_TABLE[8*i +: 8];
                    end
                end
            end
        endcase
    end

    assign wr_hit = (dec_addr_q == 8'h02) || (dec_addr_q == 8'h2B) || (dec_addr_q == 8'h2C);
    assign resp_d = ((dec_rd_q && rd_hit) || (dec_wr_q && wr_hit)) ? ACK : NACK;

    always_comb begin
        vout_status = VOUT_TABLE[7:0];
        match       = 1'b0;
        match_idx   = 3'd0;
        for (int i = 0; i < NUM_VOUT; i++) begin
            if (out_vidx == 3'(i)) vout_status = VOUT_TABLE[8*i +: 8];
        end
        // Descending scan so the lowest matching index wins.
        for (int i = NUM_VOUT - 1; i >= 0; i--) begin
            if (3'(i) <= max_eff && VOUT_TABLE[8*i +: 8] == vout_cfg_q) begin
                match     = 1'b1;
                match_idx = 3'(i);
            end
        end
    end

    // Side effects land only on the send_resp cycle.
    assign do_oc = send_resp && dec_wr_q && dec_addr_q == 8'h2B && dec_wdata_q[0];

    always_comb begin
        vout_cfg_d = vout_cfg_q;
        if (send_resp && dec_wr_q && dec_addr_q == 8'h2C) vout_cfg_d = dec_wdata_q;
        target_d = target_q;
        if (reset_from_master)  target_d = 3'd0;
        else if (do_oc && match) target_d = match_idx;
        adapt_d = ((send_resp && dec_rd_q && dec_addr_q == 8'h28) ? 1'b0 : adapt_q)
                  | (do_oc & ~match);
        sstat_d = ((send_resp && dec_rd_q && dec_addr_q == 8'h03) ? 2'b00 : sstat_q)
                  | {crc_error, par_error};
    end

    always_comb begin
        out_d = out_vidx;
        cnt_d = '0;
        if (out_vidx != target_q) begin
            if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                out_d = (target_q > out_vidx) ? out_vidx + 3'd1 : out_vidx - 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        busy_d = (out_d != target_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            dec_vld_q   <= 1'b0;
            dec_wr_q    <= 1'b0;
            dec_rd_q    <= 1'b0;
            dec_addr_q  <= 8'h00;
            dec_wdata_q <= 8'h00;
            resp_vld_q  <= 1'b0;
            resp_q      <= NACK;
            pl_tx_data  <= 16'h0000;
            vout_cfg_q  <= 8'd50;
            sstat_q     <= 2'b00;
            adapt_q     <= 1'b0;
            target_q    <= 3'd0;
            out_vidx    <= 3'd0;
            cnt_q       <= '0;
            vout_busy   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            dec_vld_q  <= rx_data_valid;
            if (rx_data_valid) begin
                dec_wr_q    <= (rx_data[23:16] == 8'h0B);
                dec_rd_q    <= (rx_data[23:16] == 8'h00) && (rx_data[15:8] == 8'h0C);
                dec_addr_q  <= (rx_data[23:16] == 8'h0B) ? rx_data[15:8] : rx_data[7:0];
                dec_wdata_q <= rx_data[7:0];
            end
            resp_vld_q <= dec_vld_q;
            if (dec_vld_q) resp_q <= resp_d;
            if (resp_vld_q) begin
                pl_tx_data <= dec_rd_q ? {resp_q, (resp_q == ACK) ? rdata : 8'h00}
                                       : {8'h00, resp_q};
            end
            vout_cfg_q <= vout_cfg_d;
            sstat_q    <= sstat_d;
            adapt_q    <= adapt_d;
            target_q   <= target_d;
            out_vidx   <= out_d;
            cnt_q      <= cnt_d;
            vout_busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_fcp_slave_ctrl.sv
// Directed bench for fcp_slave_ctrl with default parameters (levels 50/90/120, 100-cycle steps).
module tb_fcp_slave_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  max_vidx = 3'd2;
    logic        ping_from_master = 1'b0;
    logic        reset_from_master = 1'b0;
    logic        crc_error = 1'b0;
    logic        par_error = 1'b0;
    logic [23:0] rx_data = 24'h0;
    logic        rx_data_valid = 1'b0;
    logic        tx_done = 1'b0;
    logic        pl_tx_en;
    logic        pl_tx_type;
    logic [15:0] pl_tx_data;
    logic [2:0]  out_vidx;
    logic        vout_busy;

    int n_cmp = 0;
    int n_mis = 0;

    fcp_slave_ctrl dut (
        .clk               (clk),
        .rstn              (rstn),
        .max_vidx          (max_vidx),
        .ping_from_master  (ping_from_master),
        .reset_from_master (reset_from_master),
        .crc_error         (crc_error),
        .par_error         (par_error),
        .rx_data           (rx_data),
        .rx_data_valid     (rx_data_valid),
        .tx_done           (tx_done),
        .pl_tx_en          (pl_tx_en),
        .pl_tx_type        (pl_tx_type),
        .pl_tx_data        (pl_tx_data),
        .out_vidx          (out_vidx),
        .vout_busy         (vout_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Command, ping, then the PING tx_done that launches RESPOND (commit cycle).
    // Returns one cycle after the commit edge with the FSM in SEND_RESP.
    task automatic xact(input string tag, input logic [23:0] cmd, input logic [15:0] exp,
                        input logic err);
        rx_data = cmd;
        rx_data_valid = 1'b1;
        cyc(1);
        rx_data_valid = 1'b0;
        cyc(3);
        ping_from_master = 1'b1;
        #1;
        chk({tag, "_ping_en"}, 32'(pl_tx_en), 32'd1);
        chk({tag, "_ping_type"}, 32'(pl_tx_type), 32'd0);
        cyc(1);
        ping_from_master = 1'b0;
        tx_done = 1'b1;
        crc_error = err;
        #1;
        chk({tag, "_resp_en"}, 32'(pl_tx_en), 32'd1);
        chk({tag, "_resp_type"}, 32'(pl_tx_type), 32'd1);
        chk({tag, "_data"}, 32'(pl_tx_data), 32'(exp));
        cyc(1);
        tx_done = 1'b0;
        crc_error = 1'b0;
    endtask

    task automatic tx_end(input string tag);
        tx_done = 1'b1;
        #1;
        chk({tag, "_end_en"}, 32'(pl_tx_en), 32'd0);
        cyc(1);
        tx_done = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_en", 32'(pl_tx_en), 32'd0);
        chk("rst_type", 32'(pl_tx_type), 32'd0);
        chk("rst_data", 32'(pl_tx_data), 32'd0);
        chk("rst_vidx", 32'(out_vidx), 32'd0);
        chk("rst_busy", 32'(vout_busy), 32'd0);
        rstn = 1'b1;
        cyc(2);

        xact("rd_specver", 24'h000C01, 16'h0820, 1'b0);
        tx_end("rd_specver");
        xact("invalid", 24'h123456, 16'h0003, 1'b0);
        tx_end("invalid");
        xact("rd_noaddr", 24'h000C05, 16'h0300, 1'b0);
        tx_end("rd_noaddr");
        xact("wr_ro", 24'h0B0177, 16'h0003, 1'b0);
        tx_end("wr_ro");
        xact("rd_cfg_rst", 24'h000C2C, 16'h0832, 1'b0);
        tx_end("rd_cfg_rst");
        xact("rd_lvl2", 24'h000C32, 16'h0878, 1'b0);
        tx_end("rd_lvl2");
        xact("rd_lvl3", 24'h000C33, 16'h0300, 1'b0);
        tx_end("rd_lvl3");

        // VOUT_CONFIG=90 then enable: ramp 0->1 one step
        xact("wr_cfg90", 24'h0B2C5A, 16'h0008, 1'b0);
        tx_end("wr_cfg90");
        xact("wr_oc1", 24'h0B2B01, 16'h0008, 1'b0);
        chk("ramp1_busy0", 32'(vout_busy), 32'd1);
        chk("ramp1_vidx0", 32'(out_vidx), 32'd0);
        tx_end("wr_oc1");
        cyc(98);
        chk("ramp1_vidx99", 32'(out_vidx), 32'd0);
        cyc(1);
        chk("ramp1_vidx100", 32'(out_vidx), 32'd1);
        chk("ramp1_busy100", 32'(vout_busy), 32'd0);
        xact("rd_vstat", 24'h000C29, 16'h085A, 1'b0);
        tx_end("rd_vstat");

        // Unsupported level with max_vidx=1
        max_vidx = 3'd1;
        xact("rd_dcap", 24'h000C21, 16'h0801, 1'b0);
        tx_end("rd_dcap");
        xact("wr_cfg120", 24'h0B2C78, 16'h0008, 1'b0);
        tx_end("wr_cfg120");
        xact("wr_oc_bad", 24'h0B2B01, 16'h0008, 1'b0);
        tx_end("wr_oc_bad");
        chk("bad_vidx", 32'(out_vidx), 32'd1);
        chk("bad_busy", 32'(vout_busy), 32'd0);
        xact("rd_astat1", 24'h000C28, 16'h0801, 1'b0);
        tx_end("rd_astat1");
        xact("rd_astat2", 24'h000C28, 16'h0800, 1'b0);
        tx_end("rd_astat2");
        xact("rd_lvl2_m1", 24'h000C32, 16'h0300, 1'b0);
        tx_end("rd_lvl2_m1");
        max_vidx = 3'd2;

        // Master reset in IDLE ramps back to level 0
        reset_from_master = 1'b1;
        cyc(1);
        reset_from_master = 1'b0;
        chk("mrst_busy", 32'(vout_busy), 32'd1);
        cyc(100);
        chk("mrst_vidx", 32'(out_vidx), 32'd0);
        chk("mrst_busy_end", 32'(vout_busy), 32'd0);

        // Target 2 (config still 120), then retarget to 0 at +150
        xact("wr_oc_t2", 24'h0B2B01, 16'h0008, 1'b0);
        chk("t2_busy0", 32'(vout_busy), 32'd1);
        tx_end("wr_oc_t2");
        xact("wr_cfg50", 24'h0B2C32, 16'h0008, 1'b0);
        tx_end("wr_cfg50");
        cyc(91);
        chk("t2_vidx99", 32'(out_vidx), 32'd0);
        cyc(1);
        chk("t2_vidx100", 32'(out_vidx), 32'd1);
        chk("t2_busy100", 32'(vout_busy), 32'd1);
        cyc(44);
        xact("wr_oc_t0", 24'h0B2B01, 16'h0008, 1'b0);
        chk("t0_vidx150", 32'(out_vidx), 32'd1);
        tx_end("wr_oc_t0");
        cyc(48);
        chk("t0_vidx199", 32'(out_vidx), 32'd1);
        chk("t0_busy199", 32'(vout_busy), 32'd1);
        cyc(1);
        chk("t0_vidx200", 32'(out_vidx), 32'd0);
        chk("t0_busy200", 32'(vout_busy), 32'd0);

        // SSTAT set/clear priority
        crc_error = 1'b1;
        cyc(1);
        crc_error = 1'b0;
        xact("sstat1", 24'h000C03, 16'h0802, 1'b1);
        tx_end("sstat1");
        xact("sstat2", 24'h000C03, 16'h0802, 1'b0);
        tx_end("sstat2");
        xact("sstat3", 24'h000C03, 16'h0800, 1'b0);
        tx_end("sstat3");
        crc_error = 1'b1;
        par_error = 1'b1;
        cyc(1);
        crc_error = 1'b0;
        par_error = 1'b0;
        xact("sstat_both", 24'h000C03, 16'h0803, 1'b0);
        tx_end("sstat_both");

        // Move to level 1, then abort a pending write with reset_from_master
        xact("wr_cfg90b", 24'h0B2C5A, 16'h0008, 1'b0);
        tx_end("wr_cfg90b");
        xact("wr_oc1b", 24'h0B2B01, 16'h0008, 1'b0);
        tx_end("wr_oc1b");
        cyc(105);
        chk("abort_pre_vidx", 32'(out_vidx), 32'd1);
        rx_data = 24'h0B2C78;
        rx_data_valid = 1'b1;
        cyc(1);
        rx_data_valid = 1'b0;
        cyc(3);
        ping_from_master = 1'b1;
        #1;
        chk("abort_ping_en", 32'(pl_tx_en), 32'd1);
        cyc(1);
        ping_from_master = 1'b0;
        reset_from_master = 1'b1;
        tx_done = 1'b1;
        #1;
        chk("abort_en", 32'(pl_tx_en), 32'd0);
        chk("abort_type", 32'(pl_tx_type), 32'd0);
        cyc(1);
        reset_from_master = 1'b0;
        tx_done = 1'b0;
        chk("abort_busy", 32'(vout_busy), 32'd1);
        tx_done = 1'b1;
        #1;
        chk("abort_idle_en", 32'(pl_tx_en), 32'd0);
        cyc(1);
        tx_done = 1'b0;
        cyc(98);
        chk("abort_vidx100", 32'(out_vidx), 32'd1);
        cyc(1);
        chk("abort_vidx101", 32'(out_vidx), 32'd0);
        chk("abort_busy101", 32'(vout_busy), 32'd0);
        xact("abort_rd_cfg", 24'h000C2C, 16'h085A, 1'b0);
        tx_end("abort_rd_cfg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fcp_slave_ctrl.md
# fcp_slave_ctrl

Parametrised FCP slave logical layer. It sits between the FCP physical layer (rx word decode, tx serialiser) and the power stage. It decodes master SBRRD/SBRWR commands, holds the slave register file, and sequences PING/RESPOND transmissions. It drives the output-voltage level index through a stepped ramp over a configurable table of discrete voltages.

## Interface
- NUM_VOUT, 3: number of discrete voltage levels, 2..8.
- VOUT_TABLE, {8'd120,8'd90,8'd50}: packed 8*NUM_VOUT bits; entry i in bits [8i+7:8i] is level i in 0.1 V units; entry 0 is the default level.
- STEP_CYCLES, 100: dwell cycles per one-level ramp step, ≥1.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- max_vidx  in  3  highest level index the adapter supports, clamped to NUM_VOUT-1.
- ping_from_master  in  1  master ping detected (1-cycle pulse).
- reset_from_master  in  1  master reset detected (1-cycle pulse).
- crc_error, par_error  in  1  PHY error pulses.
- rx_data  in  24  received command word.
- rx_data_valid  in  1  rx_data valid (1-cycle pulse).
- tx_done  in  1  PHY finished current transmission (1-cycle pulse).
- pl_tx_en  out  1  start-transmit pulse.
- pl_tx_type  out  1  0 = PING, 1 = RESPOND.
- pl_tx_data  out  16  response payload.
- out_vidx  out  3  current output level index.
- vout_busy  out  1  ramp in progress.

## Operation
- Decode on rx_data_valid:
  - SBRWR (0x0B): rx_data[23:16]==0x0B; addr=[15:8], wdata=[7:0].
  - SBRRD (0x0C): [23:16]==0, [15:8]==0x0C; addr=[7:0].
  - Anything else is an invalid command.
- Register map:
  - 0x00 DVCTYPE=0x01.
  - 0x01 SPEC_VER=0x20.
  - 0x02 SCNTL (RW, always reads 0).
  - 0x03 SSTAT (RR): bit1 crc, bit0 parity.
  - 0x04 ID_OUI0=0xBB.
  - 0x20 CAPABILITIES=0x01.
  - 0x21 DISCRETE_CAPABILITIES={5'b0,max_vidx}.
  - 0x22 MAX_PWR=0x24.
  - 0x28 ADAPTER_STATUS: bit0 invalid-voltage-request (RR), bit1 = vout_busy (live).
  - 0x29 VOUT_STATUS = VOUT_TABLE[out_vidx].
  - 0x2B OUTPUT_CONTROL (W, reads 0).
  - 0x2C VOUT_CONFIG (RW, reset 50).
  - 0x30+i DISCRETE_VOUT_i for i ≤ max_vidx.
- RESP:
  - ACK (0x08) if the read address exists, or the write address is in {0x02,0x2B,0x2C}.
  - NACK (0x03) otherwise, and for invalid commands.
- pl_tx_data:
  - Read: {RESP, rdata}, where rdata is 0x00 on NACK.
  - Write or invalid: {8'h00, RESP}.
- Commit: writes and RR clears take effect only in the cycle send_resp is asserted. Commands aborted by reset_from_master have no side effect.
- Write 0x2B with bit0=1 looks up VOUT_CONFIG in VOUT_TABLE[0..max_vidx]:
  - Match: target index = match index.
  - No match: target unchanged, ADAPTER_STATUS bit0 set.
- Ramp:
  - While out_vidx≠target, the dwell counter counts 0..STEP_CYCLES-1. At terminal count, out_vidx moves one index toward target and the counter returns to 0.
  - Counter is held at 0 when out_vidx==target.
  - A new target mid-ramp keeps out_vidx and the counter as they are.
- reset_from_master forces target=0 (ramp down to default level) and clears the pending command.
- FSM states:
  - IDLE → SEND_PING on ping_from_master.
  - SEND_PING → IDLE on reset_from_master.
  - SEND_PING → SEND_RESP on tx_done if a command is pending, else → IDLE.
  - SEND_RESP → IDLE on tx_done or reset_from_master.
- Pending flag:
  - Set on rx_data_valid; cleared on send_resp or reset_from_master.
  - reset_from_master wins over rx_data_valid in the same cycle.
- send_ping = IDLE→SEND_PING transition; send_resp = SEND_PING→SEND_RESP transition (both combinational on next-state).
- pl_tx_en = send_ping|send_resp; pl_tx_type = (next state==SEND_RESP).

## Timing
- Reset values: pl_tx_en 0, pl_tx_type 0, pl_tx_data 0, out_vidx 0, vout_busy 0, target 0, SSTAT 0, ADAPTER_STATUS 0, VOUT_CONFIG 50, FSM IDLE, counter 0.
- rx_data_valid at cycle T: decode registered at T+1, RESP at T+2, pl_tx_data at T+3. The master-side protocol guarantees a ping no earlier than T+4.
- Read data is sampled at T+3, so SSTAT errors arriving before T+3 are reported.
- Set/clear priority:
  - An SSTAT or ADAPTER_STATUS bit set in the same cycle as its RR clear: set wins.
  - crc and parity in the same cycle both set.
- Ramp: the step from k to k±1 occurs STEP_CYCLES cycles after out_vidx≠target first holds. Full 0→2 takes 2*STEP_CYCLES cycles.
- vout_busy is registered alongside out_vidx.
- tx_done and reset_from_master in the same cycle: reset takes precedence, next state IDLE, no send_resp.

## Test plan
- SBRRD 0x000C01, then ping, then tx_done → pl_tx_en PING, then RESPOND with pl_tx_data 0x0820; next tx_done returns FSM to IDLE.
- SBRWR 0x0B2C5A, ping, then SBRWR 0x0B2B01, ping (max_vidx=2) → out_vidx 0→1 after 100 cycles; VOUT_STATUS read returns {0x08,0x5A}.
- Write VOUT_CONFIG 120 with max_vidx=1, then OUTPUT_CONTROL=1 → target unchanged; ADAPTER_STATUS read 0x01, then 0x00 on a second read.
- Target 2 requested, then target 0 written at cycle 150 → out_vidx goes 0→1 at 100, then 1→0 at 200; vout_busy deasserts at 200.
- crc_error pulse, then SSTAT read; another crc_error on the commit cycle → response 0x0802 and SSTAT stays 0x02.
- reset_from_master during SEND_PING with a command pending → no RESPOND, out_vidx ramps to 0, and the command's write has no effect.
